// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store sequencer for a big-endian,
// byte-addressed, word-wide data memory. It accepts one request at a time,
// does read-modify-write for byte/halfword stores, and does lane extraction
// plus sign/zero extension for loads.
// Optional build macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned
// halfword/word accesses skip memory and return resp_err=1. When it is not
// defined, misaligned addresses are force-aligned.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t              state_q, state_d;
  logic                r_we, r_signed;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                misalign;
  logic                in_write;

  // Offset 0 is the most significant byte (big-endian); size 2'b11 acts as word.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                          input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Splices right-justified store data into the lane the address selects.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    case (size)
      2'b00: begin
        case (off)
          2'd0:    r[31:24] = d[7:0];
          2'd1:    r[23:16] = d[7:0];
          2'd2:    r[15:8]  = d[7:0];
          default: r[7:0]   = d[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[15:0] = d[15:0];
        else        r[31:16] = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // State register; reset abandons whatever operation is in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request capture and read-word / response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= '0;
      rd_word  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_signed <= req_signed;
            r_size   <= req_size;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            rdata_q  <= '0;
            err_q    <= misalign;
          end
        end
        READ: begin
          rd_word <= mem_rdata;
          if (!r_we) rdata_q <= extract(mem_rdata, r_size, r_addr[1:0], r_signed);
        end
        default: ;
      endcase
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    in_write   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misalign)                 state_d = RESP;
          else if (req_we && req_size[1]) state_d = WRITE;
          else                          state_d = READ;
        end
      end
      READ:  state_d = r_we ? WRITE : RESP;
      WRITE: begin
        in_write = 1'b1;
        state_d  = RESP;
      end
      default: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
    endcase
  end

  // Reset masks the strobe so a pending write never lands on the reset edge.
  assign mem_wr     = in_write & ~rst;
  assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = mem_wr ? merge(rd_word, r_wdata, r_size, r_addr[1:0]) : '0;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
